// File: rtl/fpu_mul_pipe_if.sv
// Operand/result stream bundle for the binary16 multiplier.
// Latency: none (wires only).
// Backpressure: none; valid-only streams, no ready in either direction.
interface fpu_mul_pipe_if;
    logic [15:0] s_axis_a_tdata;
    logic        s_axis_a_tvalid;
    logic [15:0] s_axis_b_tdata;
    logic        s_axis_b_tvalid;
    logic [15:0] m_axis_result_tdata;
    logic        m_axis_result_tvalid;

    modport master (
        output s_axis_a_tdata, s_axis_a_tvalid, s_axis_b_tdata, s_axis_b_tvalid,
        input  m_axis_result_tdata, m_axis_result_tvalid
    );

    modport slave (
        input  s_axis_a_tdata, s_axis_a_tvalid, s_axis_b_tdata, s_axis_b_tvalid,
        output m_axis_result_tdata, m_axis_result_tvalid
    );
endinterface

// File: rtl/fpu_mul_pipe.sv
// Fully pipelined IEEE 754 binary16 multiplier, round to nearest even.
// Latency: 8 cycles from accepted operand pair to registered result.
// Backpressure: none; the pipe advances every cycle and accepts a pair whenever both valids are high.
module fpu_mul_pipe #(
    parameter int LATENCY = 8
) (
    input logic           aclk,
    input logic           aresetn,
    fpu_mul_pipe_if.slave axis
);

    typedef struct packed {
        logic sign;
        logic nan;
        logic inf;
        logic zero;
    } flags_t;

    function automatic logic [3:0] lzc11(input logic [10:0] m);
        logic [3:0] n;
        logic       found;
        n     = 4'd11;
        found = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            if (!found && m[i]) begin
                n     = 4'(10 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic [LATENCY-1:0] vld_q;

    logic [15:0]        s1_a, s1_b;
    logic [10:0]        s2_ma, s2_mb;
    logic signed [8:0]  s2_exp, s3_exp, s4_exp, s5_exp;
    flags_t             s2_flags, s3_flags, s4_flags, s5_flags, s6_flags, s7_flags;
    logic [16:0]        s3_pp_lo;
    logic [15:0]        s3_pp_hi;
    logic [21:0]        s4_prod, s5_mant, s6_mant;
    logic [8:0]         s6_exp;
    logic               s6_sticky;
    logic [18:0]        s7_sum;
    logic [15:0]        s8_dat;

    // Stage 2: unpack; subnormals are pre-normalized so the product always has its MSB in bit 21 or 20.
    logic [4:0]  a_exp, b_exp, a_e, b_e;
    logic [9:0]  a_frac, b_frac;
    logic [10:0] a_man, b_man;
    logic [3:0]  a_lz, b_lz;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    flags_t      flags_d;

    assign a_exp  = s1_a[14:10];
    assign b_exp  = s1_b[14:10];
    assign a_frac = s1_a[9:0];
    assign b_frac = s1_b[9:0];
    assign a_man  = {|a_exp, a_frac};
    assign b_man  = {|b_exp, b_frac};
    assign a_e    = (a_exp == 5'd0) ? 5'd1 : a_exp;
    assign b_e    = (b_exp == 5'd0) ? 5'd1 : b_exp;
    assign a_lz   = lzc11(a_man);
    assign b_lz   = lzc11(b_man);
    assign a_nan  = (&a_exp) & (|a_frac);
    assign b_nan  = (&b_exp) & (|b_frac);
    assign a_inf  = (&a_exp) & ~(|a_frac);
    assign b_inf  = (&b_exp) & ~(|b_frac);
    assign a_zero = ~(|a_exp) & ~(|a_frac);
    assign b_zero = ~(|b_exp) & ~(|b_frac);

    assign flags_d.sign = s1_a[15] ^ s1_b[15];
    assign flags_d.nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    assign flags_d.inf  = ~flags_d.nan & (a_inf | b_inf);
    assign flags_d.zero = ~flags_d.nan & (a_zero | b_zero);

    // Stage 5: one-bit normalize puts the hidden bit at position 21.
    logic [21:0]       norm_mant;
    logic signed [8:0] norm_exp;

    assign norm_mant = s4_prod[21] ? s4_prod : {s4_prod[20:0], 1'b0};
    assign norm_exp  = s4_exp + 9'(s4_prod[21]);

    // Stage 6: results below the normal range are shifted down to exponent 1, folding lost bits into sticky.
    logic       denorm;
    logic [8:0] sh_raw;
    logic [4:0] sh;
    logic [43:0] ext;

    assign denorm = s5_exp[8] | (s5_exp == 9'sd0);
    assign sh_raw = 9'd1 - $unsigned(s5_exp);
    assign sh     = (sh_raw > 9'd22) ? 5'd22 : sh_raw[4:0];
    assign ext    = {s5_mant, 22'd0} >> sh;

    // Stage 7: a cleared hidden bit means subnormal, so the exponent field is 0 and a rounding carry lands in it.
    logic [8:0] efield;
    logic       round_up;

    assign efield   = s6_mant[21] ? s6_exp : 9'd0;
    assign round_up = s6_mant[10] & (s6_mant[11] | (|s6_mant[9:0]) | s6_sticky);

    logic [15:0] res;

    always_comb begin
        res = {s7_flags.sign, s7_sum[14:0]};
        if (s7_flags.nan)
            res = 16'h7E00;
        else if (s7_flags.inf)
            res = {s7_flags.sign, 5'h1F, 10'h000};
        else if (s7_flags.zero)
            res = {s7_flags.sign, 15'h0000};
        else if (s7_sum[18:10] >= 9'd31)
            res = {s7_flags.sign, 5'h1F, 10'h000};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_q     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s2_ma     <= '0;
            s2_mb     <= '0;
            s2_exp    <= '0;
            s2_flags  <= '0;
            s3_pp_lo  <= '0;
            s3_pp_hi  <= '0;
            s3_exp    <= '0;
            s3_flags  <= '0;
            s4_prod   <= '0;
            s4_exp    <= '0;
            s4_flags  <= '0;
            s5_mant   <= '0;
            s5_exp    <= '0;
            s5_flags  <= '0;
            s6_mant   <= '0;
            s6_exp    <= '0;
            s6_sticky <= 1'b0;
            s6_flags  <= '0;
            s7_sum    <= '0;
            s7_flags  <= '0;
            s8_dat    <= '0;
        end else begin
            vld_q     <= {vld_q[LATENCY-2:0], axis.s_axis_a_tvalid & axis.s_axis_b_tvalid};
            s1_a      <= axis.s_axis_a_tdata;
            s1_b      <= axis.s_axis_b_tdata;

            s2_ma     <= a_man << a_lz;
            s2_mb     <= b_man << b_lz;
            s2_exp    <= 9'(a_e) + 9'(b_e) - 9'(a_lz) - 9'(b_lz) - 9'd15;
            s2_flags  <= flags_d;

            // Multiply split across two stages: partial products, then the sum.
            s3_pp_lo  <= 17'(s2_ma) * 17'(s2_mb[5:0]);
            s3_pp_hi  <= 16'(s2_ma) * 16'(s2_mb[10:6]);
            s3_exp    <= s2_exp;
            s3_flags  <= s2_flags;

            s4_prod   <= 22'(s3_pp_lo) + {s3_pp_hi, 6'd0};
            s4_exp    <= s3_exp;
            s4_flags  <= s3_flags;

            s5_mant   <= norm_mant;
            s5_exp    <= norm_exp;
            s5_flags  <= s4_flags;

            s6_mant   <= denorm ? ext[43:22] : s5_mant;
            s6_sticky <= denorm & (|ext[21:0]);
            s6_exp    <= $unsigned(s5_exp);
            s6_flags  <= s5_flags;

            s7_sum    <= {efield, s6_mant[20:11]} + 19'(round_up);
            s7_flags  <= s6_flags;

            s8_dat    <= res;
        end
    end

    assign axis.m_axis_result_tdata  = s8_dat;
    assign axis.m_axis_result_tvalid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_fpu_mul_pipe.sv
// Scoreboard bench for fpu_mul_pipe: directed binary16 vectors, a long random stream against an
// exact integer reference, valid gaps, and a reset with operations in flight.
module tb_fpu_mul_pipe;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    fpu_mul_pipe_if u_if ();

    fpu_mul_pipe #(.LATENCY(8)) u_dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axis    (u_if.slave)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          cyc;
    } sb_t;

    sb_t sb[$];
    int  cyc     = 0;
    int  n_pass  = 0;
    int  n_total = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    localparam int NDIR = 19;
    logic [15:0] dir_a [NDIR] = '{16'h3C00, 16'h4000, 16'h7978, 16'h0400, 16'h3C01, 16'h0001, 16'h0003,
                                  16'h7BFF, 16'h7C00, 16'h7E00, 16'hFC00, 16'h8000, 16'h0000, 16'h03FF,
                                  16'h7BFF, 16'hFE01, 16'h0200, 16'h03FF, 16'h3555};
    logic [15:0] dir_b [NDIR] = '{16'h3C00, 16'hC200, 16'h0001, 16'h3800, 16'h3C01, 16'h3800, 16'h3800,
                                  16'h7BFF, 16'h0000, 16'h3C00, 16'h4000, 16'h3C00, 16'hFC00, 16'h3C01,
                                  16'h3C01, 16'h7C00, 16'h4000, 16'h3C00, 16'hBC00};
    logic [15:0] dir_r [NDIR] = '{16'h3C00, 16'hC600, 16'h1978, 16'h0200, 16'h3C02, 16'h0000, 16'h0002,
                                  16'h7C00, 16'h7E00, 16'h7E00, 16'hFC00, 16'h8000, 16'h7E00, 16'h0400,
                                  16'h7C00, 16'h7E00, 16'h0400, 16'h03FF, 16'hB555};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Exact reference: the product is an integer scaled by a power of two, rounded by integer division.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic   sgn, a_inf, b_inf, a_zero, b_zero, found;
        longint ma, mb, p, q, rem, half, bits;
        int     ea, eb, s, e, k, t;
        sgn    = a[15] ^ b[15];
        a_inf  = (a[14:0] == 15'h7C00);
        b_inf  = (b[14:0] == 15'h7C00);
        a_zero = (a[14:0] == 15'h0000);
        b_zero = (b[14:0] == 15'h0000);
        if (a[14:0] > 15'h7C00 || b[14:0] > 15'h7C00) return 16'h7E00;
        if ((a_inf && b_zero) || (b_inf && a_zero)) return 16'h7E00;
        if (a_inf || b_inf) return {sgn, 15'h7C00};
        if (a_zero || b_zero) return {sgn, 15'h0000};
        ma = (a[14:10] == 5'd0) ? longint'(a[9:0]) : longint'({1'b1, a[9:0]});
        mb = (b[14:10] == 5'd0) ? longint'(b[9:0]) : longint'({1'b1, b[9:0]});
        ea = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
        eb = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
        p  = ma * mb;
        s  = ea + eb - 50;
        e  = 1;
        found = 1'b0;
        for (int x = 31; x >= 1; x--) begin
            t = x - 15 - s;
            if (!found && (t <= 0 || (t < 62 && p >= (longint'(1) << t)))) begin
                e     = x;
                found = 1'b1;
            end
        end
        k = s - e + 25;
        if (k >= 0) begin
            q = p << k;
        end else begin
            rem  = p & ((longint'(1) << (-k)) - 1);
            half = longint'(1) << (-k - 1);
            q    = p >> (-k);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        bits = longint'(e - 1) * 1024 + q;
        if (bits >= 64'h7C00) return {sgn, 15'h7C00};
        return {sgn, bits[14:0]};
    endfunction

    function automatic logic [15:0] rnd_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[14:10] = 5'($urandom_range(4, 26));
        return h;
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic va, input logic vb, input logic [15:0] res);
        @(posedge aclk);
        #1;
        u_if.s_axis_a_tdata  = a;
        u_if.s_axis_b_tdata  = b;
        u_if.s_axis_a_tvalid = va;
        u_if.s_axis_b_tvalid = vb;
        if (va && vb) sb.push_back('{a, b, res, cyc});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge aclk);
            n++;
        end
        repeat (2) @(posedge aclk);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    endtask

    // Monitor: every presented result must match the oldest pending entry, exactly 8 cycles after issue.
    always @(negedge aclk) begin
        sb_t e;
        if (aresetn && u_if.m_axis_result_tvalid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: got tdata %h with nothing pending, expected tvalid=0 (cycle %0d)",
                         u_if.m_axis_result_tdata, cyc);
            end else begin
                e = sb.pop_front();
                chk($sformatf("result %h*%h", e.a, e.b), u_if.m_axis_result_tdata, e.res);
                chk("latency", 16'(cyc - e.cyc), 16'd8);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, expected finish before 1000000");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, b;
        aresetn              = 1'b0;
        u_if.s_axis_a_tdata  = '0;
        u_if.s_axis_b_tdata  = '0;
        u_if.s_axis_a_tvalid = 1'b0;
        u_if.s_axis_b_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_tvalid", 16'(u_if.m_axis_result_tvalid), 16'd0);
        chk("reset_tdata", u_if.m_axis_result_tdata, 16'h0000);
        aresetn = 1'b1;

        for (int i = 0; i < NDIR; i++) drive(dir_a[i], dir_b[i], 1'b1, 1'b1, dir_r[i]);
        drive(16'h3C00, 16'h3C00, 1'b1, 1'b0, 16'h0000);
        drive(16'h3C00, 16'h3C00, 1'b0, 1'b1, 16'h0000);
        drive(16'h4000, 16'h4000, 1'b1, 1'b1, 16'h4400);
        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        drain();

        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) repeat (3) drive(16'h3C00, 16'h3C00, 1'b0, 1'b0, 16'h0000);
            a = rnd_half();
            b = rnd_half();
            if (i == 1000)      drive(a, b, 1'b1, 1'b0, 16'h0000);
            else if (i == 3000) drive(a, b, 1'b0, 1'b1, 16'h0000);
            else                drive(a, b, 1'b1, 1'b1, ref_mul(a, b));
        end
        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        drain();

        for (int i = 0; i < 5; i++) drive(dir_a[i], dir_b[i], 1'b1, 1'b1, dir_r[i]);
        #2;
        aresetn = 1'b0;
        #1;
        chk("midreset_tvalid", 16'(u_if.m_axis_result_tvalid), 16'd0);
        chk("midreset_tdata", u_if.m_axis_result_tdata, 16'h0000);
        sb.delete();
        u_if.s_axis_a_tvalid = 1'b0;
        u_if.s_axis_b_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        repeat (20) @(posedge aclk);

        for (int i = 5; i < 9; i++) drive(dir_a[i], dir_b[i], 1'b1, 1'b1, dir_r[i]);
        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpu_mul_pipe.md
Name: fpu_mul_pipe

Overview:
Fully pipelined IEEE 754 binary16 (half-precision) floating-point multiplier with an AXI-Stream-style valid-only interface. It accepts one operand pair per clock and returns the rounded product a fixed 8 cycles later. It is the multiply unit of the 16-bit FPU and sits alongside the add/sub pipe.

Parameters:
- LATENCY, 8, input-to-output pipeline depth in clock cycles; only 8 is supported and verified.

Ports:
- aclk  input  1  clock; all state updates on the rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- s_axis_a_tdata  input  16  operand A, binary16.
- s_axis_a_tvalid  input  1  operand A valid.
- s_axis_b_tdata  input  16  operand B, binary16.
- s_axis_b_tvalid  input  1  operand B valid.
- m_axis_result_tdata  output  16  product, binary16.
- m_axis_result_tvalid  output  1  result valid.

Behaviour:
- Interface: one clock (aclk); reset is asynchronous and active-low (aresetn).
- Reset: while aresetn=0, all pipeline registers clear; m_axis_result_tdata=16'h0000 and m_axis_result_tvalid=0. A reset mid-stream discards all in-flight operations. After release, the first valid result appears 8 cycles after the first accepted pair.
- Handshake: no tready and no backpressure; the pipeline advances every cycle. A pair is accepted on a rising edge where s_axis_a_tvalid & s_axis_b_tvalid = 1.
- Valid tracking: that AND is shifted through an 8-deep valid chain. m_axis_result_tvalid equals the AND sampled 8 edges earlier.
- Data path: data is computed regardless of valid. Output data is don't-care when tvalid=0, but must be deterministic (no X after reset).
- Throughput: 1 result per cycle. Result for inputs sampled at edge N is registered at edge N+8.
- Arithmetic:
  - Sign = sign_a XOR sign_b.
  - Unpack: a normal operand gives mantissa {1,frac} with exponent e. A subnormal operand (exp=0, frac≠0) gives {0,frac} with effective exponent 1.
  - Multiply the 11x11 mantissas to a 22-bit product.
  - Exponent = ea+eb-15, held in a signed width of at least 7 bits.
  - Normalize with a leading-zero count so that subnormal inputs are handled exactly.
  - Round to nearest, ties to even, using guard/round/sticky from all discarded bits. A mantissa overflow after rounding increments the exponent.
  - Output subnormals: if the biased exponent is ≤0, right-shift with sticky before rounding and emit exp=0. A subnormal that rounds up to 2^-14 becomes the smallest normal (0x0400).
  - Overflow: biased exponent ≥31 after rounding gives ±Inf (exp=31, frac=0).
  - Underflow to zero yields a signed zero.
- Special cases, checked in priority order:
  1. Any NaN input gives 16'h7E00.
  2. Inf x 0 gives 16'h7E00.
  3. Inf x finite nonzero gives ±Inf (0x7C00 / 0xFC00).
  4. 0 x finite gives signed zero (0x0000 / 0x8000).
- Canonical NaN output is always 16'h7E00, positive, with no payload propagation.
- Stage split: 8 stages, e.g. input regs/unpack, special detect + LZC, multiply (two stages), normalize, round-shift, round, output regs. Special-case flags travel alongside the data.

Test Plan:
- Basic: a=0x3C00, b=0x3C00, valid=1 -> tdata=0x3C00, tvalid=1 exactly 8 cycles later. Also 0x4000 x 0xC200 -> 0xC600 (2 x -3 = -6).
- Subnormal input: 0x7978 x 0x0001 -> 0x1978. Also 0x0400 x 0x3800 -> 0x0200 (normal to subnormal result).
- Rounding:
  - 0x3C01 x 0x3C01 -> 0x3C02 (round down).
  - 0x0001 x 0x3800 -> 0x0000 (tie to even).
  - 0x0003 x 0x3800 -> 0x0002 (tie to even, up).
- Overflow/specials:
  - 0x7BFF x 0x7BFF -> 0x7C00.
  - 0x7C00 x 0x0000 -> 0x7E00.
  - 0x7E00 x 0x3C00 -> 0x7E00.
  - 0xFC00 x 0x4000 -> 0xFC00.
  - 0x8000 x 0x3C00 -> 0x8000.
- Streaming: 100k random pairs back-to-back, with valid deasserted for 3 cycles mid-stream. Each output must match the reference model 8 cycles later, and tvalid must reproduce the 3-cycle gap 8 cycles later.
- Reset: assert aresetn=0 with 5 ops in flight -> tvalid=0 and tdata=0 immediately. No stale results are emitted after release.
